// File: rtl/mixer_n.sv
// Time-multiplexed N-channel mixer: one shared multiply-accumulate, one channel per clk cycle.
// Define MIXER_SATURATE_EN to clamp the result and report clip; otherwise the result wraps.
module mixer_n #(
    parameter int NUM_CH   = 4,
    parameter int BITDEPTH = 14,
    parameter int SHIFT    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_clock,
    input  logic [NUM_CH*BITDEPTH-1:0]   in,
    input  logic [NUM_CH*8-1:0]          gain,
    input  logic [NUM_CH-1:0]            mute,
    output logic [BITDEPTH-1:0]          mix,
    output logic                         mix_valid,
    output logic                         clip,
    output logic                         busy,
    output logic                         overrun
);

    localparam int AW = BITDEPTH + 2 + $clog2(NUM_CH);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = BITDEPTH + 2;
    localparam int PW = BITDEPTH + 9;

`ifdef MIXER_SATURATE_EN
    localparam logic signed [AW-1:0] RMAX = AW'((2 ** (BITDEPTH - 1)) - 1);
    localparam logic signed [AW-1:0] RMIN = -RMAX - AW'(1);
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                       state;
    logic                         sc_q;
    logic                         sc_rise;
    logic [NUM_CH*BITDEPTH-1:0]   in_p0;
    logic [NUM_CH*8-1:0]          gain_p0;
    logic [NUM_CH-1:0]            mute_p0;
    logic [CW-1:0]                ch;
    logic signed [AW-1:0]         acc;
    logic signed [TW-1:0]         term;
    logic [BITDEPTH:0]            res;

    // Offset-binary sample times Q1.7 gain, floored back to sample scale.
    function automatic logic signed [TW-1:0] scale(input logic [BITDEPTH-1:0] smp,
                                                   input logic [7:0] g,
                                                   input logic m);
        logic signed [BITDEPTH-1:0] s;
        logic signed [PW-1:0]       p;
        s = $signed({~smp[BITDEPTH-1], smp[BITDEPTH-2:0]});
        p = s * $signed({1'b0, g});
        return m ? '0 : $signed(p[PW-1:7]);
    endfunction

    // Returns {clip, signed result} after the attenuation shift.
    function automatic logic [BITDEPTH:0] saturate(input logic signed [AW-1:0] a);
`ifdef MIXER_SATURATE_EN
        logic signed [AW-1:0] r;
        r = a >>> SHIFT;
        if (r > RMAX)
            return {1'b1, RMAX[BITDEPTH-1:0]};
        else if (r < RMIN)
            return {1'b1, RMIN[BITDEPTH-1:0]};
        else
            return {1'b0, r[BITDEPTH-1:0]};
`else
        return {1'b0, BITDEPTH'(a >>> SHIFT)};
`endif
    endfunction

    assign sc_rise = sample_clock & ~sc_q;
    assign term    = scale(in_p0[ch*BITDEPTH +: BITDEPTH], gain_p0[ch*8 +: 8], mute_p0[ch]);
    assign res     = saturate(acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q      <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            mix_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
            mix       <= {1'b1, {(BITDEPTH-1){1'b0}}};
        end else begin
            sc_q      <= sample_clock;
            mix_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sc_rise) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (sc_rise)
                        overrun <= 1'b1;
                    if (ch == CW'(NUM_CH - 1))
                        state <= DONE;
                end
                DONE: begin
                    if (sc_rise)
                        overrun <= 1'b1;
                    mix       <= {~res[BITDEPTH-1], res[BITDEPTH-2:0]};
                    clip      <= res[BITDEPTH];
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Snapshot stage and accumulator; the FSM alone decides when these are meaningful.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (sc_rise) begin
                    in_p0   <= in;
                    gain_p0 <= gain;
                    mute_p0 <= mute;
                    acc     <= '0;
                    ch      <= '0;
                end
            end
            ACCUM: begin
                acc <= acc + AW'(term);
                ch  <= ch + 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mixer_n.sv
// Self-checking bench for mixer_n: directed test-plan cases plus random mixes against an arithmetic model.
module tb_mixer_n;
    localparam int N  = 4;
    localparam int BD = 14;
    localparam int SH = 2;
    localparam int MID = 8192;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_clock;
    logic [N*BD-1:0]   in_v;
    logic [N*8-1:0]    gain_v;
    logic [N-1:0]      mute_v;
    logic [BD-1:0]     mix;
    logic              mix_valid;
    logic              clip;
    logic              busy;
    logic              overrun;

    int vectors = 0;
    int miscompares = 0;
    int smp[N];
    int gn[N];
    int mu[N];

    always #5 clk = ~clk;

    mixer_n #(.NUM_CH(N), .BITDEPTH(BD), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .sample_clock(sample_clock),
        .in(in_v), .gain(gain_v), .mute(mute_v),
        .mix(mix), .mix_valid(mix_valid), .clip(clip),
        .busy(busy), .overrun(overrun)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0)
            q = q - 1;
        return q;
    endfunction

    // Reference: signed sample times gain/128 (floored), summed, /2^SH (floored), then clamp or wrap.
    task automatic model(output int m, output int c);
        int sum;
        int r;
        sum = 0;
        for (int k = 0; k < N; k++)
            if (mu[k] == 0)
                sum += floor_div((smp[k] - MID) * gn[k], 128);
        r = floor_div(sum, 1 << SH);
`ifdef MIXER_SATURATE_EN
        c = (r > MID - 1 || r < -MID) ? 1 : 0;
        if (r > MID - 1) r = MID - 1;
        if (r < -MID) r = -MID;
        m = r + MID;
`else
        c = 0;
        m = (((r + MID) % (2 * MID)) + 2 * MID) % (2 * MID);
`endif
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            in_v[k*BD +: BD] = BD'(smp[k]);
            gain_v[k*8 +: 8] = 8'(gn[k]);
            mute_v[k]        = (mu[k] != 0);
        end
    endtask

    task automatic set_all(input int s, input int g, input int m);
        for (int k = 0; k < N; k++) begin
            smp[k] = s; gn[k] = g; mu[k] = m;
        end
    endtask

    // Starts a mix (unless the edge is already pending), scrambles inputs after the snapshot,
    // then checks latency, result, strobe width and hold.
    task automatic run_mix(input string tag, input int exp_mix, input int exp_clip, input bit pre_raised);
        int n;
        if (!pre_raised) begin
            @(negedge clk);
            sample_clock = 1'b1;
        end
        @(negedge clk);
        sample_clock = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        in_v   = 56'({$urandom(), $urandom()});
        gain_v = 32'($urandom());
        mute_v = 4'($urandom());
        n = 0;
        while (!mix_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, N + 1);
        check({tag, "_mix"}, int'(mix), exp_mix);
        check({tag, "_clip"}, int'(clip), exp_clip);
        check({tag, "_idle"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_strobe"}, int'(mix_valid), 0);
        check({tag, "_hold"}, int'(mix), exp_mix);
        drive();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int em;
        int ec;
        int cnt;
        int seen;
        rst = 1'b1;
        sample_clock = 1'b0;
        set_all(MID, 8'h80, 0);
        drive();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mix", int'(mix), MID);
        check("rst_valid", int'(mix_valid), 0);
        check("rst_clip", int'(clip), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);

        // Silence in, silence out.
        run_mix("silence", MID, 0, 1'b0);

        // Full-scale positive on ch0 only.
        smp[0] = 16383;
        drive();
        run_mix("ch0_full", 10239, 0, 1'b0);

        // Same with ch0 muted.
        mu[0] = 1;
        drive();
        run_mix("ch0_mute", MID, 0, 1'b0);

        // All channels full scale at maximum gain.
        set_all(16383, 8'hFF, 0);
        drive();
`ifdef MIXER_SATURATE_EN
        run_mix("max_gain", 16383, 1, 1'b0);
`else
        run_mix("max_gain", 8126, 0, 1'b0);
`endif

        // Second rising edge two cycles into an accumulation.
        set_all(MID, 8'h80, 0);
        smp[0] = 16383;
        drive();
        @(negedge clk);
        sample_clock = 1'b1;
        @(negedge clk);
        sample_clock = 1'b0;
        check("ovr_before", int'(overrun), 0);
        @(negedge clk);
        sample_clock = 1'b1;
        @(negedge clk);
        sample_clock = 1'b0;
        check("ovr_set", int'(overrun), 1);
        cnt = 0;
        seen = -1;
        repeat (12) begin
            @(negedge clk);
            if (mix_valid) begin
                cnt++;
                seen = int'(mix);
            end
        end
        check("ovr_valid_count", cnt, 1);
        check("ovr_mix", seen, 10239);
        run_mix("ovr_next", 10239, 0, 1'b0);
        check("ovr_sticky", int'(overrun), 1);

        // Reset at edge 2 of an accumulation aborts the mix.
        set_all(MID, 8'h80, 0);
        smp[1] = 0;
        drive();
        model(em, ec);
        @(negedge clk);
        sample_clock = 1'b1;
        @(negedge clk);
        sample_clock = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_mix", int'(mix), MID);
        check("abort_overrun", int'(overrun), 0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (mix_valid) cnt++;
        end
        check("abort_no_valid", cnt, 0);
        run_mix("abort_next", em, ec, 1'b0);

        // sample_clock already high when reset releases.
        @(negedge clk);
        rst = 1'b1;
        sample_clock = 1'b1;
        set_all(MID, 8'h80, 0);
        smp[2] = 12000;
        drive();
        model(em, ec);
        @(negedge clk);
        rst = 1'b0;
        run_mix("post_rst_edge", em, ec, 1'b1);

        // Random mixes against the model.
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < N; k++) begin
                smp[k] = int'($urandom_range(0, 16383));
                gn[k]  = int'($urandom_range(0, 255));
                mu[k]  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            end
            if (t < 4)
                for (int k = 0; k < N; k++) begin
                    smp[k] = (t[0]) ? 0 : 16383;
                    gn[k]  = 255;
                    mu[k]  = 0;
                end
            drive();
            model(em, ec);
            run_mix($sformatf("rand%0d", t), em, ec, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
